// File: rtl/ultrasonic_echo_emulator.sv
// ultrasonic_echo_emulator
// Responder side of an HC-SR04-style trigger/echo interface. A qualified
// trigger pulse starts a measurement. After a fixed burst delay, echo is
// driven high for distancia * CYCLES_PER_CM cycles.
// Optional feature macro: EMU_TIMEOUT_EN. When it is defined, an
// out-of-range distance produces a TIMEOUT_CYCLES wide echo, as a real
// sensor does with no target. When it is undefined, an out-of-range
// distance produces no echo at all, and done still pulses.
module ultrasonic_echo_emulator #(
    parameter int CYCLES_PER_CM   = 2941,
    parameter int MIN_TRIG_CYCLES = 500,
    parameter int BURST_CYCLES    = 5000,
    parameter int MAX_CM          = 400,
    parameter int TIMEOUT_CYCLES  = 1_900_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       trigger,
    input  logic [8:0] distancia,
    output logic       echo,
    output logic       busy,
    output logic       done,
    output logic [2:0] db_estado
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        TRIG   = 3'd1,
        BURST  = 3'd2,
        ECHO   = 3'd3,
        DONE   = 3'd4,
        NOECHO = 3'd5
    } state_t;

    localparam logic [21:0] CPC_C   = 22'(CYCLES_PER_CM);
    localparam logic [21:0] MIN_C   = 22'(MIN_TRIG_CYCLES);
    localparam logic [21:0] BURST_C = 22'(BURST_CYCLES);
    localparam logic [8:0]  MAX_C   = 9'(MAX_CM);
`ifdef EMU_TIMEOUT_EN
    localparam logic [21:0] TIMEOUT_C = 22'(TIMEOUT_CYCLES);
`endif

    state_t      state_r;
    logic        sync1_r;
    logic        trig_s;
    logic        trig_prev_r;
    logic [21:0] cnt_r;
    logic [21:0] width_r;
    logic [21:0] width_calc_s;
    logic        in_range_s;
`ifndef EMU_TIMEOUT_EN
    logic        oor_r;
`endif

    assign db_estado = state_r;

    // Bring the asynchronous trigger into the clock domain with two flops
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_r <= 1'b0;
            trig_s  <= 1'b0;
        end else begin
            sync1_r <= trigger;
            trig_s  <= sync1_r;
        end
    end

    // Echo width for the distance currently presented, used only at latch time
    always_comb begin
        in_range_s   = 1'b0;
        width_calc_s = 22'd0;
        if ((distancia != 9'd0) && (distancia <= MAX_C)) begin
            in_range_s   = 1'b1;
            width_calc_s = {13'd0, distancia} * CPC_C;
        end else begin
            in_range_s   = 1'b0;
`ifdef EMU_TIMEOUT_EN
            width_calc_s = TIMEOUT_C;
`else
            width_calc_s = 22'd0;
`endif
        end
    end

    // Measurement sequencer with registered echo/busy/done outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            cnt_r       <= 22'd0;
            width_r     <= 22'd0;
            trig_prev_r <= 1'b0;
            echo        <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
`ifndef EMU_TIMEOUT_EN
            oor_r       <= 1'b0;
`endif
        end else begin
            trig_prev_r <= trig_s;
            case (state_r)
                IDLE: begin
                    echo <= 1'b0;
                    busy <= 1'b0;
                    done <= 1'b0;
                    // Only a rising edge observed here starts a measurement;
                    // the first high sample already counts toward the width
                    if (trig_s && !trig_prev_r) begin
                        cnt_r   <= 22'd1;
                        state_r <= TRIG;
                    end else begin
                        cnt_r   <= 22'd0;
                    end
                end
                TRIG: begin
                    if (trig_s) begin
                        if (cnt_r < MIN_C) begin
                            cnt_r <= cnt_r + 22'd1;
                        end
                    end else if (cnt_r >= MIN_C) begin
                        width_r <= width_calc_s;
`ifndef EMU_TIMEOUT_EN
                        oor_r   <= !in_range_s;
`endif
                        cnt_r   <= 22'd0;
                        busy    <= 1'b1;
                        state_r <= BURST;
                    end else begin
                        cnt_r   <= 22'd0;
                        state_r <= IDLE;
                    end
                end
                BURST: begin
                    if (cnt_r == BURST_C - 22'd1) begin
                        cnt_r <= 22'd0;
`ifdef EMU_TIMEOUT_EN
                        echo    <= 1'b1;
                        state_r <= ECHO;
`else
                        if (oor_r) begin
                            state_r <= NOECHO;
                        end else begin
                            echo    <= 1'b1;
                            state_r <= ECHO;
                        end
`endif
                    end else begin
                        cnt_r <= cnt_r + 22'd1;
                    end
                end
                ECHO: begin
                    if (cnt_r == width_r - 22'd1) begin
                        cnt_r   <= 22'd0;
                        echo    <= 1'b0;
                        done    <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        cnt_r <= cnt_r + 22'd1;
                    end
                end
`ifndef EMU_TIMEOUT_EN
                NOECHO: begin
                    echo    <= 1'b0;
                    done    <= 1'b1;
                    state_r <= DONE;
                end
`endif
                DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    cnt_r   <= 22'd0;
                    echo    <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule
